// File: rtl/sb_tx_serializer.sv
// Sideband transmit serializer: shifts one 64-bit packet out LSB first and enforces a GAP_UI idle gap between packets.
// Optional build macro SB_SER_PKT_CNT_EN adds a 16-bit transmitted-packet counter output (o_pkt_cnt).
module sb_tx_serializer #(
  parameter int PKT_W  = 64,
  parameter int GAP_UI = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [PKT_W-1:0] i_packet,
  input  logic             i_packet_valid,
  output logic             o_ready,
  output logic             o_txdata_sb,
  output logic             o_txclk_en,
  output logic             o_ser_done,
  output logic             o_busy
`ifdef SB_SER_PKT_CNT_EN
  ,
  output logic [15:0]      o_pkt_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam logic [6:0] BIT_LAST   = 7'(PKT_W - 1);
  localparam logic [6:0] BIT_PENULT = 7'(PKT_W - 2);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_UI - 1);

  state_e           state_q;
  // Bit 0 goes straight to the line on accept, so only bits 1..PKT_W-1 are held here.
  logic [PKT_W-2:0] shreg_q;
  logic [6:0]       bit_cnt_q;
  logic [7:0]       gap_cnt_q;
  logic             txdata_q;
  logic             txclk_en_q;
  logic             ser_done_q;
  logic             busy_q;
  logic             ready_s;
  logic             accept_s;

  // Ready is open in IDLE and in the final GAP cycle so back-to-back packets see exactly GAP_UI idle UI.
  always_comb begin
    ready_s  = 1'b0;
    accept_s = 1'b0;
    if ((state_q == ST_IDLE) || ((state_q == ST_GAP) && (gap_cnt_q == GAP_LAST))) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
    if (ready_s && i_packet_valid) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Serializer FSM with registered line outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= 7'd0;
      gap_cnt_q  <= 8'd0;
      txdata_q   <= 1'b0;
      txclk_en_q <= 1'b0;
      ser_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else if (accept_s) begin
      state_q    <= ST_SHIFT;
      shreg_q    <= i_packet[PKT_W-1:1];
      bit_cnt_q  <= 7'd0;
      gap_cnt_q  <= 8'd0;
      txdata_q   <= i_packet[0];
      txclk_en_q <= 1'b1;
      ser_done_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          txdata_q   <= 1'b0;
          txclk_en_q <= 1'b0;
          ser_done_q <= 1'b0;
          busy_q     <= 1'b0;
        end
        ST_SHIFT: begin
          if (bit_cnt_q == BIT_LAST) begin
            state_q    <= ST_GAP;
            gap_cnt_q  <= 8'd0;
            txdata_q   <= 1'b0;
            txclk_en_q <= 1'b0;
            ser_done_q <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            shreg_q    <= shreg_q >> 1;
            bit_cnt_q  <= bit_cnt_q + 7'd1;
            txdata_q   <= shreg_q[0];
            ser_done_q <= (bit_cnt_q == BIT_PENULT);
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= 8'd0;
            busy_q    <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          txdata_q   <= 1'b0;
          txclk_en_q <= 1'b0;
          ser_done_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

`ifdef SB_SER_PKT_CNT_EN
  logic [15:0] pkt_cnt_q;

  // Debug count of completed packets, bumped the cycle after each done pulse; wraps naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pkt_cnt_q <= 16'd0;
    end else if (ser_done_q) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end else begin
      pkt_cnt_q <= pkt_cnt_q;
    end
  end

  assign o_pkt_cnt = pkt_cnt_q;
`endif

  assign o_ready     = ready_s;
  assign o_txdata_sb = txdata_q;
  assign o_txclk_en  = txclk_en_q;
  assign o_ser_done  = ser_done_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Directed bench for sb_tx_serializer: DUT a uses GAP_UI=32, DUT b uses GAP_UI=1 for the minimum-gap case.
module tb_sb_tx_serializer;

  logic        clk;
  logic        rst_n_a, valid_a, ready_a, txd_a, en_a, done_a, busy_a;
  logic        rst_n_b, valid_b, ready_b, txd_b, en_b, done_b, busy_b;
  logic [63:0] pkt_a, pkt_b;
`ifdef SB_SER_PKT_CNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] P_SINGLE = 64'h1234_FFFF_0000_A5A5;
  localparam logic [63:0] P_B2B_1  = 64'h8000_0000_0000_0001;
  localparam logic [63:0] P_B2B_2  = 64'h0F0F_3C3C_AAAA_5555;
  localparam logic [63:0] P_BUSY   = 64'hCAFE_0123_4567_89AB;
  localparam logic [63:0] P_INTRUD = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] P_RST    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] P_FRESH  = 64'h0000_0001_8000_0000;

  sb_tx_serializer #(.PKT_W(64), .GAP_UI(32)) u_dut_a (
    .i_clk          (clk),
    .i_rst_n        (rst_n_a),
    .i_packet       (pkt_a),
    .i_packet_valid (valid_a),
    .o_ready        (ready_a),
    .o_txdata_sb    (txd_a),
    .o_txclk_en     (en_a),
    .o_ser_done     (done_a),
    .o_busy         (busy_a)
`ifdef SB_SER_PKT_CNT_EN
    ,
    .o_pkt_cnt      (cnt_a)
`endif
  );

  sb_tx_serializer #(.PKT_W(64), .GAP_UI(1)) u_dut_b (
    .i_clk          (clk),
    .i_rst_n        (rst_n_b),
    .i_packet       (pkt_b),
    .i_packet_valid (valid_b),
    .o_ready        (ready_b),
    .o_txdata_sb    (txd_b),
    .o_txclk_en     (en_b),
    .o_ser_done     (done_b),
    .o_busy         (busy_b)
`ifdef SB_SER_PKT_CNT_EN
    ,
    .o_pkt_cnt      (cnt_b)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sample 64 consecutive cycles just after each rising edge.
  task automatic capture(input bit use_b, output logic [63:0] bits, output int en_n, output int done_n);
    en_n   = 0;
    done_n = 0;
    bits   = 64'd0;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk);
      #1;
      bits[k] = use_b ? txd_b : txd_a;
      en_n   += int'(use_b ? en_b : en_a);
      done_n += int'(use_b ? done_b : done_a);
    end
  endtask

  task automatic wait_ready(input bit use_b);
    int n = 0;
    while (!(use_b ? ready_b : ready_a) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if ((use_b ? ready_b : ready_a) !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: ready=%b after %0d cycles, expected 1", use_b ? ready_b : ready_a, n);
    end
  endtask

  task automatic test_reset;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0;
    pkt_a = 64'd0; pkt_b = 64'd0;
    #1;
    checks++;
    if ({txd_a, en_a, done_a, busy_a} !== 4'b0000) begin
      errors++; $display("FAIL reset_outs_a: got %b expected 0000", {txd_a, en_a, done_a, busy_a});
    end
    checks++;
    if ({ready_a, ready_b} !== 2'b11) begin
      errors++; $display("FAIL reset_ready: got %b expected 11", {ready_a, ready_b});
    end
`ifdef SB_SER_PKT_CNT_EN
    checks++;
    if (cnt_a !== 16'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt_a);
    end
`endif
    @(negedge clk);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({ready_a, busy_a, ready_b, busy_b} !== 4'b1010) begin
      errors++; $display("FAIL post_reset_idle: got %b expected 1010", {ready_a, busy_a, ready_b, busy_b});
    end
  endtask

  task automatic test_single;
    logic [63:0] bits;
    int en_n, done_n;
    wait_ready(1'b0);
    pkt_a = P_SINGLE; valid_a = 1'b1;
    capture(1'b0, bits, en_n, done_n);
    valid_a = 1'b0;
    checks++;
    if (bits !== P_SINGLE) begin
      errors++; $display("FAIL single_bits: got %h expected %h", bits, P_SINGLE);
    end
    checks++;
    if (en_n !== 64 || done_n !== 1 || done_a !== 1'b1) begin
      errors++; $display("FAIL single_en_done: en=%0d done=%0d last_done=%b expected 64 1 1", en_n, done_n, done_a);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({txd_a, en_a, done_a, busy_a, ready_a} !== 5'b00010) begin
      errors++; $display("FAIL single_gap_entry: got %b expected 00010", {txd_a, en_a, done_a, busy_a, ready_a});
    end
    wait_ready(1'b0);
  endtask

  task automatic test_back_to_back;
    logic [63:0] bits;
    int en_n, done_n, gap_n, acc;
    wait_ready(1'b0);
    pkt_a = P_B2B_1; valid_a = 1'b1;
    capture(1'b0, bits, en_n, done_n);
    pkt_a = P_B2B_2;
    checks++;
    if (bits !== P_B2B_1) begin
      errors++; $display("FAIL b2b_first_bits: got %h expected %h", bits, P_B2B_1);
    end
    gap_n = 0;
    acc = -1;
    for (int c = 65; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (en_a === 1'b0 && txd_a === 1'b0) gap_n++;
      if (ready_a === 1'b1) begin
        acc = c;
        break;
      end
    end
    checks++;
    if (acc !== 96 || gap_n !== 32) begin
      errors++; $display("FAIL b2b_gap: accept at N+%0d idle=%0d expected N+96 idle=32", acc, gap_n);
    end
    capture(1'b0, bits, en_n, done_n);
    valid_a = 1'b0;
    checks++;
    if (bits !== P_B2B_2 || en_n !== 64 || done_n !== 1) begin
      errors++; $display("FAIL b2b_second: bits=%h en=%0d done=%0d expected %h 64 1", bits, en_n, done_n, P_B2B_2);
    end
    wait_ready(1'b0);
  endtask

  task automatic test_valid_while_busy;
    logic [63:0] bits;
    int done_n;
    wait_ready(1'b0);
    pkt_a = P_BUSY; valid_a = 1'b1;
    done_n = 0;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk);
      #1;
      bits[k] = txd_a;
      done_n += int'(done_a);
      if (k == 0) valid_a = 1'b0;
      if (k == 9) begin valid_a = 1'b1; pkt_a = P_INTRUD; end
      if (k == 10) valid_a = 1'b0;
    end
    checks++;
    if (bits !== P_BUSY || done_n !== 1) begin
      errors++; $display("FAIL busy_ignore: bits=%h done=%0d expected %h 1", bits, done_n, P_BUSY);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({en_a, busy_a, done_a} !== 3'b010) begin
      errors++; $display("FAIL busy_no_restart: got %b expected 010", {en_a, busy_a, done_a});
    end
    wait_ready(1'b0);
  endtask

  task automatic test_reset_mid_shift;
    logic [63:0] bits, ref_pkt;
    int en_n, done_n;
    ref_pkt = P_RST;
    bits = 64'd0;
    wait_ready(1'b0);
    pkt_a = P_RST; valid_a = 1'b1;
    done_n = 0;
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk);
      #1;
      bits[k] = txd_a;
      done_n += int'(done_a);
      if (k == 0) valid_a = 1'b0;
    end
    checks++;
    if (bits[20:0] !== ref_pkt[20:0]) begin
      errors++; $display("FAIL rst_partial_bits: got %h expected %h", bits[20:0], ref_pkt[20:0]);
    end
    rst_n_a = 1'b0;
    #1;
    checks++;
    if ({txd_a, en_a, done_a, busy_a, ready_a} !== 5'b00001) begin
      errors++; $display("FAIL rst_async_outs: got %b expected 00001", {txd_a, en_a, done_a, busy_a, ready_a});
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      done_n += int'(done_a);
    end
    @(negedge clk);
    rst_n_a = 1'b1;
    @(posedge clk);
    #1;
    done_n += int'(done_a);
    checks++;
    if ({ready_a, busy_a} !== 2'b10 || done_n !== 0) begin
      errors++; $display("FAIL rst_release: ready/busy=%b done=%0d expected 10 0", {ready_a, busy_a}, done_n);
    end
    pkt_a = P_FRESH; valid_a = 1'b1;
    capture(1'b0, bits, en_n, done_n);
    valid_a = 1'b0;
    checks++;
    if (bits !== P_FRESH || en_n !== 64 || done_n !== 1) begin
      errors++; $display("FAIL rst_fresh: bits=%h en=%0d done=%0d expected %h 64 1", bits, en_n, done_n, P_FRESH);
    end
    wait_ready(1'b0);
  endtask

  task automatic test_min_gap;
    logic [63:0] bits;
    int en_n, done_n;
    wait_ready(1'b1);
    pkt_b = P_B2B_1; valid_b = 1'b1;
    capture(1'b1, bits, en_n, done_n);
    pkt_b = P_B2B_2;
    checks++;
    if (bits !== P_B2B_1 || done_n !== 1) begin
      errors++; $display("FAIL mingap_first: bits=%h done=%0d expected %h 1", bits, done_n, P_B2B_1);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({ready_b, en_b, txd_b, busy_b} !== 4'b1001) begin
      errors++; $display("FAIL mingap_gap_cycle: got %b expected 1001", {ready_b, en_b, txd_b, busy_b});
    end
    capture(1'b1, bits, en_n, done_n);
    valid_b = 1'b0;
    checks++;
    if (bits !== P_B2B_2 || en_n !== 64 || done_n !== 1) begin
      errors++; $display("FAIL mingap_second: bits=%h en=%0d done=%0d expected %h 64 1", bits, en_n, done_n, P_B2B_2);
    end
  endtask

`ifdef SB_SER_PKT_CNT_EN
  task automatic test_pkt_cnt;
    logic [63:0] bits;
    int en_n, done_n;
    rst_n_a = 1'b0;
    @(negedge clk);
    rst_n_a = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      wait_ready(1'b0);
      pkt_a = P_SINGLE; valid_a = 1'b1;
      capture(1'b0, bits, en_n, done_n);
      valid_a = 1'b0;
    end
    @(posedge clk);
    #1;
    checks++;
    if (cnt_a !== 16'd3) begin
      errors++; $display("FAIL pkt_cnt_three: got %0d expected 3", cnt_a);
    end
    rst_n_a = 1'b0;
    #1;
    checks++;
    if (cnt_a !== 16'd0) begin
      errors++; $display("FAIL pkt_cnt_reset: got %0d expected 0", cnt_a);
    end
    @(negedge clk);
    rst_n_a = 1'b1;
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_valid_while_busy();
    test_reset_mid_shift();
    test_min_gap();
`ifdef SB_SER_PKT_CNT_EN
    test_pkt_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
